// File: rtl/psram_qspi_responder_pkg.sv
// Constants and types shared between the QSPI PSRAM responder and its initiator side.
package psram_qspi_responder_pkg;

  localparam logic [7:0]  OP_QUAD_WRITE       = 8'h38;
  localparam logic [7:0]  OP_FAST_QUAD_READ   = 8'hEB;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 6;
  localparam int unsigned NIB_W               = 4;
  localparam int unsigned QSPI_ADDR_W         = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADRS   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_WDATA  = 3'd4,
    ST_RDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } qspi_state_e;

endpackage

// File: rtl/psram_qspi_responder_if.sv
// QPI bus between an initiator and the PSRAM responder, plus responder status.
interface psram_qspi_responder_if;
  import psram_qspi_responder_pkg::*;

  logic             ram_clk;
  logic             ram_ce;
  logic [NIB_W-1:0] ram_dq_in;
  logic [NIB_W-1:0] ram_dq_out;
  logic             ram_dq_oe;
  logic             cmd_err;
  logic             busy;

  modport master (output ram_clk, ram_ce, ram_dq_in,
                  input  ram_dq_out, ram_dq_oe, cmd_err, busy);
  modport slave  (input  ram_clk, ram_ce, ram_dq_in,
                  output ram_dq_out, ram_dq_oe, cmd_err, busy);
endinterface

// File: rtl/ram_byte_array.sv
// Single-port byte RAM, one-cycle registered read; contents are never reset.
module ram_byte_array #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata <= mem_q[addr];
  end
endmodule

// File: rtl/psram_qspi_responder.sv
// QPI-mode PSRAM responder: oversamples the serial bus on iSCLK, decodes quad write /
// fast quad read and serves a small internal byte array with page-wrapped bursts.
module psram_qspi_responder
  import psram_qspi_responder_pkg::*;
#(
  parameter int unsigned pMemAdrsWidth = 8,
  parameter int unsigned pWaitCycles   = DEFAULT_WAIT_CYCLES,
  parameter int unsigned pPageWidth    = 10
) (
  input  logic             iSCLK,
  input  logic             inSRST,
  input  logic             iRamClk,
  input  logic             iRamCe,
  input  logic [NIB_W-1:0] iRamDq,
  output logic [NIB_W-1:0] oRamDq,
  output logic             oRamDqOe,
  output logic             oCmdErr,
  output logic             oBusy
);
  localparam logic [QSPI_ADDR_W-1:0] PAGE_MASK =
    QSPI_ADDR_W'((64'd1 << pPageWidth) - 64'd1);
  localparam logic [7:0] WAIT_LAST = 8'(pWaitCycles - 32'd1);

  logic             clk_meta_q, clk_sync_q, clk_prev_q;
  logic             ce_meta_q, ce_sync_q, ce_prev_q;
  logic [NIB_W-1:0] dq_meta_q, dq_sync_q;
  logic [1:0]       rst_dly_q;

  qspi_state_e            state_q, state_d;
  logic [2:0]             nib_cnt_q, nib_cnt_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic [7:0]             opcode_q, opcode_d;
  logic [QSPI_ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [NIB_W-1:0]       wr_hi_q, wr_hi_d;
  logic [7:0]             rd_byte_q, rd_byte_d;
  logic                   lo_phase_q, lo_phase_d;
  logic [NIB_W-1:0]       dq_q, dq_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   cmd_err_q, cmd_err_d;
  logic                   busy_q, busy_d;
  logic                   armed_q, armed_d;

  logic       rise, fall, ce_fall;
  logic       ram_we;
  logic [7:0] ram_wdata, ram_rdata;

  // Equal-depth synchronisers so sampled data lines up with the detected clock edge.
  always_ff @(posedge iSCLK or negedge inSRST) begin
    if (!inSRST) begin
      clk_meta_q <= 1'b0; clk_sync_q <= 1'b0; clk_prev_q <= 1'b0;
      ce_meta_q  <= 1'b1; ce_sync_q  <= 1'b1; ce_prev_q  <= 1'b1;
      dq_meta_q  <= '0;   dq_sync_q  <= '0;
      rst_dly_q  <= '0;
    end else begin
      clk_meta_q <= iRamClk; clk_sync_q <= clk_meta_q; clk_prev_q <= clk_sync_q;
      ce_meta_q  <= iRamCe;  ce_sync_q  <= ce_meta_q;  ce_prev_q  <= ce_sync_q;
      dq_meta_q  <= iRamDq;  dq_sync_q  <= dq_meta_q;
      rst_dly_q  <= {rst_dly_q[0], 1'b1};
    end
  end

  assign rise     = clk_sync_q & ~clk_prev_q & ~ce_sync_q;
  assign fall     = ~clk_sync_q & clk_prev_q & ~ce_sync_q;
  // A CE low held across reset must not look like a new transfer.
  assign ce_fall  = ce_prev_q & ~ce_sync_q & armed_q;
  assign addr_inc = (addr_q & ~PAGE_MASK) | ((addr_q + QSPI_ADDR_W'(1)) & PAGE_MASK);

  always_comb begin
    state_d    = state_q;
    nib_cnt_d  = nib_cnt_q;
    wait_cnt_d = wait_cnt_q;
    opcode_d   = opcode_q;
    addr_d     = addr_q;
    wr_hi_d    = wr_hi_q;
    rd_byte_d  = rd_byte_q;
    lo_phase_d = lo_phase_q;
    dq_d       = dq_q;
    dq_oe_d    = dq_oe_q;
    cmd_err_d  = 1'b0;
    armed_d    = armed_q | (rst_dly_q[1] & ce_sync_q);
    ram_we     = 1'b0;
    ram_wdata  = {wr_hi_q, dq_sync_q};

    case (state_q)
      ST_IDLE: begin
        if (ce_fall) begin
          state_d   = ST_CMD;
          nib_cnt_d = '0;
        end
      end
      ST_CMD: begin
        if (rise) begin
          opcode_d  = {opcode_q[3:0], dq_sync_q};
          nib_cnt_d = nib_cnt_q + 3'd1;
          if (nib_cnt_q == 3'd1) begin
            nib_cnt_d = '0;
            if ({opcode_q[3:0], dq_sync_q} inside {OP_QUAD_WRITE, OP_FAST_QUAD_READ}) begin
              state_d = ST_ADRS;
            end else begin
              state_d   = ST_IGNORE;
              cmd_err_d = 1'b1;
            end
          end
        end
      end
      ST_ADRS: begin
        if (rise) begin
          addr_d    = {addr_q[QSPI_ADDR_W-NIB_W-1:0], dq_sync_q};
          nib_cnt_d = nib_cnt_q + 3'd1;
          if (nib_cnt_q == 3'd5) begin
            nib_cnt_d  = '0;
            wait_cnt_d = '0;
            lo_phase_d = 1'b0;
            if (opcode_q == OP_QUAD_WRITE) state_d = ST_WDATA;
            else if (pWaitCycles == 32'd0)  state_d = ST_RDATA;
            else                            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // The array read at addr_q runs continuously, so the first byte is ready by RDATA.
        if (rise) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == WAIT_LAST) state_d = ST_RDATA;
        end
      end
      ST_WDATA: begin
        if (rise) begin
          if (!lo_phase_q) begin
            wr_hi_d    = dq_sync_q;
            lo_phase_d = 1'b1;
          end else begin
            ram_we     = 1'b1;
            addr_d     = addr_inc;
            lo_phase_d = 1'b0;
          end
        end
      end
      ST_RDATA: begin
        if (fall) begin
          dq_oe_d = 1'b1;
          if (!lo_phase_q) begin
            rd_byte_d  = ram_rdata;
            dq_d       = ram_rdata[7:4];
            addr_d     = addr_inc;
            lo_phase_d = 1'b1;
          end else begin
            dq_d       = rd_byte_q[3:0];
            lo_phase_d = 1'b0;
          end
        end
      end
      ST_IGNORE: ;
      default: state_d = ST_IDLE;
    endcase

    // CE high aborts everything, dropping any half-assembled byte.
    if (ce_sync_q) begin
      state_d    = ST_IDLE;
      nib_cnt_d  = '0;
      wait_cnt_d = '0;
      lo_phase_d = 1'b0;
      dq_d       = '0;
      dq_oe_d    = 1'b0;
    end

    busy_d = (state_d != ST_IDLE) & ~ce_sync_q;
  end

  always_ff @(posedge iSCLK or negedge inSRST) begin
    if (!inSRST) begin
      state_q    <= ST_IDLE;
      nib_cnt_q  <= '0;
      wait_cnt_q <= '0;
      opcode_q   <= '0;
      addr_q     <= '0;
      wr_hi_q    <= '0;
      rd_byte_q  <= '0;
      lo_phase_q <= 1'b0;
      dq_q       <= '0;
      dq_oe_q    <= 1'b0;
      cmd_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_cnt_q  <= nib_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      opcode_q   <= opcode_d;
      addr_q     <= addr_d;
      wr_hi_q    <= wr_hi_d;
      rd_byte_q  <= rd_byte_d;
      lo_phase_q <= lo_phase_d;
      dq_q       <= dq_d;
      dq_oe_q    <= dq_oe_d;
      cmd_err_q  <= cmd_err_d;
      busy_q     <= busy_d;
      armed_q    <= armed_d;
    end
  end

  ram_byte_array #(.ADDR_W(pMemAdrsWidth)) u_ram (
    .clk   (iSCLK),
    .we    (ram_we),
    .addr  (addr_q[pMemAdrsWidth-1:0]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign oRamDq   = dq_q;
  assign oRamDqOe = dq_oe_q;
  assign oCmdErr  = cmd_err_q;
  assign oBusy    = busy_q;
endmodule

// File: tb/tb_psram_qspi_responder.sv
// Directed bench for psram_qspi_responder: write/read bursts, page wrap, bad opcode,
// partial-byte abort, reset during read and a full-rate 16-byte burst.
module tb_psram_qspi_responder;
  import psram_qspi_responder_pkg::*;

  localparam int unsigned WAITS = 6;

  logic sclk = 1'b0;
  logic srst_n;
  psram_qspi_responder_if bus();

  always #5 sclk = ~sclk;

  psram_qspi_responder #(.pMemAdrsWidth(8), .pWaitCycles(WAITS), .pPageWidth(10)) dut (
    .iSCLK    (sclk),
    .inSRST   (srst_n),
    .iRamClk  (bus.ram_clk),
    .iRamCe   (bus.ram_ce),
    .iRamDq   (bus.ram_dq_in),
    .oRamDq   (bus.ram_dq_out),
    .oRamDqOe (bus.ram_dq_oe),
    .oCmdErr  (bus.cmd_err),
    .oBusy    (bus.busy)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         half  = 3;
  int         err_pulses;
  logic       oe_seen;
  logic [3:0] dq_seen;
  logic [7:0] wbuf [16];
  logic [7:0] ebuf [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n iSCLK cycles while logging responder outputs.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge sclk);
      err_pulses += int'(bus.cmd_err);
      oe_seen    |= bus.ram_dq_oe;
      dq_seen    |= bus.ram_dq_out;
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    bus.ram_dq_in = n;
    tick(half);
    bus.ram_clk = 1'b1;
    tick(half);
    bus.ram_clk = 1'b0;
  endtask

  task automatic read_nib(output logic [3:0] n, output logic oe);
    tick(half);
    bus.ram_clk = 1'b1;
    tick(half);
    n  = bus.ram_dq_out;
    oe = bus.ram_dq_oe;
    bus.ram_clk = 1'b0;
  endtask

  task automatic begin_xfer(input logic [7:0] op, input logic [23:0] a);
    bus.ram_ce = 1'b0;
    tick(4);
    send_nib(op[7:4]);
    send_nib(op[3:0]);
    for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
  endtask

  task automatic end_xfer();
    bus.ram_clk = 1'b0;
    bus.ram_ce  = 1'b1;
    tick(6);
  endtask

  task automatic write_bytes(input logic [23:0] a, input int n);
    begin_xfer(OP_QUAD_WRITE, a);
    for (int i = 0; i < n; i++) begin
      send_nib(wbuf[i][7:4]);
      send_nib(wbuf[i][3:0]);
    end
    end_xfer();
  endtask

  task automatic read_check(input string tag, input logic [23:0] a, input int n);
    logic [3:0] hi, lo;
    logic       oe_h, oe_l;
    begin_xfer(OP_FAST_QUAD_READ, a);
    chk({tag, " oe before data"}, 32'(bus.ram_dq_oe), 32'h0);
    repeat (WAITS) send_nib(4'h0);
    bus.ram_dq_in = 4'hF;
    for (int i = 0; i < n; i++) begin
      read_nib(hi, oe_h);
      read_nib(lo, oe_l);
      chk($sformatf("%s b%0d hi", tag, i), 32'(hi), 32'(ebuf[i][7:4]));
      chk($sformatf("%s b%0d lo", tag, i), 32'(lo), 32'(ebuf[i][3:0]));
      chk($sformatf("%s b%0d oe", tag, i), 32'(oe_h & oe_l), 32'h1);
    end
    end_xfer();
  endtask

  initial begin
    logic [3:0] hi;
    logic       oe;
    err_pulses    = 0;
    oe_seen       = 1'b0;
    dq_seen       = '0;
    bus.ram_clk   = 1'b0;
    bus.ram_ce    = 1'b1;
    bus.ram_dq_in = 4'h0;
    srst_n        = 1'b1;
    #2 srst_n     = 1'b0;
    tick(3);
    chk("reset oe",   32'(bus.ram_dq_oe),  32'h0);
    chk("reset dq",   32'(bus.ram_dq_out), 32'h0);
    chk("reset err",  32'(bus.cmd_err),    32'h0);
    chk("reset busy", 32'(bus.busy),       32'h0);
    srst_n = 1'b1;
    tick(4);

    // Basic write then read at 0x10.
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    bus.ram_ce = 1'b0;
    tick(4);
    send_nib(4'h3);
    chk("busy in cmd", 32'(bus.busy), 32'h1);
    bus.ram_ce = 1'b1;
    tick(6);
    write_bytes(24'h000010, 2);
    ebuf[0] = 8'hA5; ebuf[1] = 8'h3C;
    read_check("rd10", 24'h000010, 2);
    chk("oe after ce high", 32'(bus.ram_dq_oe), 32'h0);

    // Page wrap: second byte lands at 0x000.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_bytes(24'h0003FF, 2);
    ebuf[0] = 8'h11; ebuf[1] = 8'h22;
    read_check("rd3ff", 24'h0003FF, 2);
    ebuf[0] = 8'h22;
    read_check("rd000", 24'h000000, 1);

    // Unsupported opcode.
    err_pulses = 0; oe_seen = 1'b0; dq_seen = '0;
    bus.ram_ce = 1'b0;
    tick(4);
    send_nib(4'h9); send_nib(4'hF);
    repeat (6) send_nib(4'h5);
    chk("busy in ignore", 32'(bus.busy), 32'h1);
    end_xfer();
    chk("cmderr pulses", 32'(err_pulses), 32'h1);
    chk("cmderr oe",     32'(oe_seen),    32'h0);
    chk("cmderr dq",     32'(dq_seen),    32'h0);
    ebuf[0] = 8'hA5; ebuf[1] = 8'h3C;
    read_check("rd10 after err", 24'h000010, 2);

    // Partial byte then CE high: no write.
    wbuf[0] = 8'h5A;
    write_bytes(24'h000020, 1);
    begin_xfer(OP_QUAD_WRITE, 24'h000020);
    send_nib(4'h7);
    bus.ram_ce = 1'b1;
    tick(3);
    chk("idle after abort", 32'(bus.busy), 32'h0);
    tick(4);
    ebuf[0] = 8'h5A;
    read_check("rd20", 24'h000020, 1);

    // Reset during RDATA, CE kept low across reset.
    wbuf[0] = 8'hC3;
    write_bytes(24'h000040, 1);
    begin_xfer(OP_FAST_QUAD_READ, 24'h000040);
    repeat (WAITS) send_nib(4'h0);
    read_nib(hi, oe);
    chk("rst rd hi", 32'(hi), 32'hC);
    chk("rst rd oe", 32'(oe), 32'h1);
    @(negedge sclk);
    srst_n = 1'b0;
    #1;
    chk("rst oe drop",   32'(bus.ram_dq_oe),  32'h0);
    chk("rst dq clear",  32'(bus.ram_dq_out), 32'h0);
    chk("rst busy drop", 32'(bus.busy),       32'h0);
    tick(3);
    srst_n = 1'b1;
    repeat (4) send_nib(4'h3);
    chk("no start w/o ce fall", 32'(bus.busy), 32'h0);
    end_xfer();
    ebuf[0] = 8'hC3;
    read_check("rd40 after rst", 24'h000040, 1);
    ebuf[0] = 8'hA5; ebuf[1] = 8'h3C;
    read_check("rd10 after rst", 24'h000010, 2);

    // 16-byte burst with iRamClk at iSCLK/4.
    half = 2;
    for (int i = 0; i < 16; i++) begin
      wbuf[i] = 8'((i * 8'h1D) ^ 8'h96);
      ebuf[i] = wbuf[i];
    end
    write_bytes(24'h000080, 16);
    read_check("burst", 24'h000080, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
